// File: rtl/rf_write_arbiter_pkg.sv
// Shared defaults and request classification for the register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ADDR_W      = 7;
    localparam int DEF_DATA_W      = 65;
    localparam int DEF_NUM_ENTRIES = 96;
    localparam int CNT_W           = 16;

    // What an accepted request turns into: a real write, or a dropped request.
    typedef enum logic [1:0] {
        REQ_WRITE   = 2'd0,
        REQ_ZERO    = 2'd1,
        REQ_ILLEGAL = 2'd2
    } reqKind_e;

    // Address 0 is the hardwired zero register; anything past the file is illegal.
    function automatic reqKind_e classifyAddr(input logic [31:0] addr,
                                              input logic [31:0] numEntries);
        reqKind_e kind;
        if (addr >= numEntries) begin
            kind = REQ_ILLEGAL;
        end else if (addr == 32'd0) begin
            kind = REQ_ZERO;
        end else begin
            kind = REQ_WRITE;
        end
        return kind;
    endfunction

    // Pointer width that still works for a single requester.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick2.sv
// Round-robin scanner that picks up to two register writes with distinct addresses.
module rr_pick2
    import rf_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    localparam int RR_W       = ptrWidth(NUM_REQ)
) (
    input  logic                       enable_i,
    input  logic [RR_W-1:0]            rr_i,
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  data_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic                       slot0Valid_o,
    output logic [ADDR_W-1:0]          slot0Addr_o,
    output logic [DATA_W-1:0]          slot0Data_o,
    output logic                       slot1Valid_o,
    output logic [ADDR_W-1:0]          slot1Addr_o,
    output logic [DATA_W-1:0]          slot1Data_o,
    output logic                       anyGrant_o,
    output logic [RR_W-1:0]            nextRr_o,
    output logic                       conflict_o,
    output logic                       illegal_o
);

    logic [RR_W-1:0]    idxSel;
    logic [ADDR_W-1:0]  curAddr;
    reqKind_e           curKind;
    logic               inWindow;
    logic [NUM_REQ-1:0] grant;
    logic               s0Valid;
    logic [ADDR_W-1:0]  s0Addr;
    logic [DATA_W-1:0]  s0Data;
    logic               s1Valid;
    logic [ADDR_W-1:0]  s1Addr;
    logic [DATA_W-1:0]  s1Data;
    logic               anyGrant;
    logic [RR_W-1:0]    nextRr;
    logic               conflict;
    logic               illegal;

    // Walk a doubled index range so every requester index is loop-derived; only the
    // NUM_REQ entries starting at rr are live, and the walk stops once slot 1 is filled.
    always_comb begin
        grant    = '0;
        s0Valid  = 1'b0;
        s0Addr   = '0;
        s0Data   = '0;
        s1Valid  = 1'b0;
        s1Addr   = '0;
        s1Data   = '0;
        anyGrant = 1'b0;
        nextRr   = rr_i;
        conflict = 1'b0;
        illegal  = 1'b0;
        idxSel   = '0;
        curAddr  = '0;
        curKind  = REQ_WRITE;
        inWindow = 1'b0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            idxSel   = RR_W'(k % NUM_REQ);
            curAddr  = addr_i[idxSel * ADDR_W +: ADDR_W];
            curKind  = classifyAddr(32'(curAddr), 32'(NUM_ENTRIES));
            inWindow = (k >= int'(rr_i)) && (k < int'(rr_i) + NUM_REQ);
            if (enable_i && inWindow && !s1Valid && valid_i[idxSel]) begin
                if (curKind != REQ_WRITE) begin
                    grant[idxSel] = 1'b1;
                    anyGrant      = 1'b1;
                    nextRr        = (idxSel == RR_W'(NUM_REQ - 1)) ? '0 : idxSel + RR_W'(1);
                    if (curKind == REQ_ILLEGAL) begin
                        illegal = 1'b1;
                    end
                end else if (!s0Valid) begin
                    grant[idxSel] = 1'b1;
                    anyGrant      = 1'b1;
                    nextRr        = (idxSel == RR_W'(NUM_REQ - 1)) ? '0 : idxSel + RR_W'(1);
                    s0Valid       = 1'b1;
                    s0Addr        = curAddr;
                    s0Data        = data_i[idxSel * DATA_W +: DATA_W];
                end else if (curAddr == s0Addr) begin
                    conflict = 1'b1;
                end else begin
                    grant[idxSel] = 1'b1;
                    anyGrant      = 1'b1;
                    nextRr        = (idxSel == RR_W'(NUM_REQ - 1)) ? '0 : idxSel + RR_W'(1);
                    s1Valid       = 1'b1;
                    s1Addr        = curAddr;
                    s1Data        = data_i[idxSel * DATA_W +: DATA_W];
                end
            end
        end
    end

    assign grant_o      = grant;
    assign slot0Valid_o = s0Valid;
    assign slot0Addr_o  = s0Addr;
    assign slot0Data_o  = s0Data;
    assign slot1Valid_o = s1Valid;
    assign slot1Addr_o  = s1Addr;
    assign slot1Data_o  = s1Data;
    assign anyGrant_o   = anyGrant;
    assign nextRr_o     = nextRr;
    assign conflict_o   = conflict;
    assign illegal_o    = illegal;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file writeback arbiter: two registered write ports fed by a round-robin picker.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_stall,
    input  logic [NUM_REQ-1:0]         io_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  io_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  io_req_data,
    output logic [NUM_REQ-1:0]         io_req_ready,
    output logic                       io_write_ports_0_valid,
    output logic [ADDR_W-1:0]          io_write_ports_0_bits_addr,
    output logic [DATA_W-1:0]          io_write_ports_0_bits_data,
    output logic                       io_write_ports_1_valid,
    output logic [ADDR_W-1:0]          io_write_ports_1_bits_addr,
    output logic [DATA_W-1:0]          io_write_ports_1_bits_data,
    output logic                       io_err_addr,
    output logic [CNT_W-1:0]           io_conflict_count
);

    localparam int RR_W = ptrWidth(NUM_REQ);

    logic [RR_W-1:0]    rr_q;
    logic [RR_W-1:0]    rr_d;
    logic               errAddr_q;
    logic               errAddr_d;
    logic [CNT_W-1:0]   conflictCount_q;
    logic [CNT_W-1:0]   conflictCount_d;
    logic               port0Valid_q;
    logic [ADDR_W-1:0]  port0Addr_q;
    logic [DATA_W-1:0]  port0Data_q;
    logic               port1Valid_q;
    logic [ADDR_W-1:0]  port1Addr_q;
    logic [DATA_W-1:0]  port1Data_q;

    logic               pickEnable;
    logic [NUM_REQ-1:0] pickGrant;
    logic               pickS0Valid;
    logic [ADDR_W-1:0]  pickS0Addr;
    logic [DATA_W-1:0]  pickS0Data;
    logic               pickS1Valid;
    logic [ADDR_W-1:0]  pickS1Addr;
    logic [DATA_W-1:0]  pickS1Data;
    logic               pickAnyGrant;
    logic [RR_W-1:0]    pickNextRr;
    logic               pickConflict;
    logic               pickIllegal;

    // Grants are only offered outside reset and while not stalled.
    assign pickEnable = reset & ~io_stall;

    rr_pick2 #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) uPick (
        .enable_i     (pickEnable),
        .rr_i         (rr_q),
        .valid_i      (io_req_valid),
        .addr_i       (io_req_addr),
        .data_i       (io_req_data),
        .grant_o      (pickGrant),
        .slot0Valid_o (pickS0Valid),
        .slot0Addr_o  (pickS0Addr),
        .slot0Data_o  (pickS0Data),
        .slot1Valid_o (pickS1Valid),
        .slot1Addr_o  (pickS1Addr),
        .slot1Data_o  (pickS1Data),
        .anyGrant_o   (pickAnyGrant),
        .nextRr_o     (pickNextRr),
        .conflict_o   (pickConflict),
        .illegal_o    (pickIllegal)
    );

    assign io_req_ready = pickGrant;

    // Pointer follows the last grant, error flag is sticky, conflict counter saturates.
    always_comb begin
        rr_d            = rr_q;
        errAddr_d       = errAddr_q;
        conflictCount_d = conflictCount_q;
        if (pickAnyGrant) begin
            rr_d = pickNextRr;
        end
        if (pickIllegal) begin
            errAddr_d = 1'b1;
        end
        if (pickConflict && (conflictCount_q != {CNT_W{1'b1}})) begin
            conflictCount_d = conflictCount_q + CNT_W'(1);
        end
    end

    // Register the write ports and arbiter state; reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_q            <= '0;
            errAddr_q       <= 1'b0;
            conflictCount_q <= '0;
            port0Valid_q    <= 1'b0;
            port0Addr_q     <= '0;
            port0Data_q     <= '0;
            port1Valid_q    <= 1'b0;
            port1Addr_q     <= '0;
            port1Data_q     <= '0;
        end else begin
            rr_q            <= rr_d;
            errAddr_q       <= errAddr_d;
            conflictCount_q <= conflictCount_d;
            port0Valid_q    <= pickS0Valid;
            port0Addr_q     <= pickS0Addr;
            port0Data_q     <= pickS0Data;
            port1Valid_q    <= pickS1Valid;
            port1Addr_q     <= pickS1Addr;
            port1Data_q     <= pickS1Data;
        end
    end

    assign io_write_ports_0_valid     = port0Valid_q;
    assign io_write_ports_0_bits_addr = port0Addr_q;
    assign io_write_ports_0_bits_data = port0Data_q;
    assign io_write_ports_1_valid     = port1Valid_q;
    assign io_write_ports_1_bits_addr = port1Addr_q;
    assign io_write_ports_1_bits_data = port1Data_q;
    assign io_err_addr                = errAddr_q;
    assign io_conflict_count          = conflictCount_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter with a position-list reference model.
module tb_rf_write_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 65;
    localparam int NUM_ENTRIES = 96;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      io_stall;
    logic [NUM_REQ-1:0]        io_req_valid;
    logic [NUM_REQ*ADDR_W-1:0] io_req_addr;
    logic [NUM_REQ*DATA_W-1:0] io_req_data;
    logic [NUM_REQ-1:0]        io_req_ready;
    logic                      io_write_ports_0_valid;
    logic [ADDR_W-1:0]         io_write_ports_0_bits_addr;
    logic [DATA_W-1:0]         io_write_ports_0_bits_data;
    logic                      io_write_ports_1_valid;
    logic [ADDR_W-1:0]         io_write_ports_1_bits_addr;
    logic [DATA_W-1:0]         io_write_ports_1_bits_data;
    logic                      io_err_addr;
    logic [15:0]               io_conflict_count;

    logic [ADDR_W-1:0] reqAddr [NUM_REQ];
    logic [DATA_W-1:0] reqData [NUM_REQ];

    int checks = 0;
    int errors = 0;

    // Reference model state: pointer, sticky flag, counter and expected port contents.
    bit                 modelKnown = 1'b0;
    int                 mRr;
    bit                 mErr;
    logic [15:0]        mCnt;
    bit                 eV0;
    bit                 eV1;
    logic [ADDR_W-1:0]  eA0;
    logic [ADDR_W-1:0]  eA1;
    logic [DATA_W-1:0]  eD0;
    logic [DATA_W-1:0]  eD1;
    logic [NUM_REQ-1:0] mGrant;
    bit                 mS0V;
    bit                 mS1V;
    logic [ADDR_W-1:0]  mS0A;
    logic [ADDR_W-1:0]  mS1A;
    logic [DATA_W-1:0]  mS0D;
    logic [DATA_W-1:0]  mS1D;
    bit                 mConflict;
    bit                 mIllegal;
    bit                 mAny;
    int                 mLast;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NUM_REQ; g++) begin : gFlat
        assign io_req_addr[g*ADDR_W +: ADDR_W] = reqAddr[g];
        assign io_req_data[g*DATA_W +: DATA_W] = reqData[g];
    end

    rf_write_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_ENTRIES (NUM_ENTRIES)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_stall                   (io_stall),
        .io_req_valid               (io_req_valid),
        .io_req_addr                (io_req_addr),
        .io_req_data                (io_req_data),
        .io_req_ready               (io_req_ready),
        .io_write_ports_0_valid     (io_write_ports_0_valid),
        .io_write_ports_0_bits_addr (io_write_ports_0_bits_addr),
        .io_write_ports_0_bits_data (io_write_ports_0_bits_data),
        .io_write_ports_1_valid     (io_write_ports_1_valid),
        .io_write_ports_1_bits_addr (io_write_ports_1_bits_addr),
        .io_write_ports_1_bits_data (io_write_ports_1_bits_data),
        .io_err_addr                (io_err_addr),
        .io_conflict_count          (io_conflict_count)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic bit isWrite(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < NUM_ENTRIES);
    endfunction

    function automatic logic [DATA_W-1:0] dataFor(input int i);
        return DATA_W'({1'b1, 32'hD0D0_0000, 32'(i)});
    endfunction

    function automatic logic [ADDR_W-1:0] randAddr();
        int r;
        logic [ADDR_W-1:0] a;
        r = $urandom_range(0, 9);
        case (r)
            0:       a = '0;
            1:       a = ADDR_W'($urandom_range(NUM_ENTRIES, 127));
            2:       a = ADDR_W'(NUM_ENTRIES - 1);
            default: a = ADDR_W'($urandom_range(1, 4));
        endcase
        return a;
    endfunction

    // Model: list requesters in pointer order, pick slot 0 as the first real writer and
    // slot 1 as the first later writer with a different address; dropped requests are
    // granted only if they sit before slot 1 in that order.
    task automatic modelEvaluate();
        int order[$];
        int writers[$];
        int s0Pos;
        int s1Pos;
        int cutPos;
        int i;
        mGrant    = '0;
        mS0V      = 1'b0;
        mS1V      = 1'b0;
        mS0A      = '0;
        mS1A      = '0;
        mS0D      = '0;
        mS1D      = '0;
        mConflict = 1'b0;
        mIllegal  = 1'b0;
        mAny      = 1'b0;
        mLast     = mRr;
        if (reset !== 1'b1 || io_stall !== 1'b0) return;
        for (int k = 0; k < NUM_REQ; k++) order.push_back((mRr + k) % NUM_REQ);
        for (int p = 0; p < NUM_REQ; p++) begin
            if (io_req_valid[order[p]] && isWrite(reqAddr[order[p]])) writers.push_back(p);
        end
        s0Pos = -1;
        s1Pos = -1;
        if (writers.size() > 0) s0Pos = writers[0];
        for (int w = 1; w < writers.size(); w++) begin
            if (s1Pos < 0 && reqAddr[order[writers[w]]] != reqAddr[order[s0Pos]]) s1Pos = writers[w];
        end
        cutPos = (s1Pos >= 0) ? s1Pos : NUM_REQ;
        foreach (writers[w]) begin
            if (writers[w] > s0Pos && writers[w] < cutPos) mConflict = 1'b1;
        end
        for (int p = 0; p < NUM_REQ; p++) begin
            i = order[p];
            if (p == s0Pos || p == s1Pos ||
                (p < cutPos && io_req_valid[i] && !isWrite(reqAddr[i]))) begin
                mGrant[i] = 1'b1;
                mAny      = 1'b1;
                mLast     = i;
                if (int'(reqAddr[i]) >= NUM_ENTRIES) mIllegal = 1'b1;
            end
        end
        if (s0Pos >= 0) begin
            mS0V = 1'b1;
            mS0A = reqAddr[order[s0Pos]];
            mS0D = reqData[order[s0Pos]];
        end
        if (s1Pos >= 0) begin
            mS1V = 1'b1;
            mS1A = reqAddr[order[s1Pos]];
            mS1D = reqData[order[s1Pos]];
        end
    endtask

    // Compare process: inputs are stable at the falling edge, so check registered outputs
    // from the previous rising edge, check ready, then advance the model across the next edge.
    always @(negedge clock) begin
        if (modelKnown) begin
            checkOutput("port0_valid", io_write_ports_0_valid, eV0);
            checkOutput("port1_valid", io_write_ports_1_valid, eV1);
            if (eV0) begin
                checkOutput("port0_addr", io_write_ports_0_bits_addr, eA0);
                checkOutput("port0_data", io_write_ports_0_bits_data, eD0);
            end
            if (eV1) begin
                checkOutput("port1_addr", io_write_ports_1_bits_addr, eA1);
                checkOutput("port1_data", io_write_ports_1_bits_data, eD1);
            end
            checkOutput("err_addr", io_err_addr, mErr);
            checkOutput("conflict_count", io_conflict_count, mCnt);
        end
        modelEvaluate();
        if (modelKnown || reset === 1'b0) begin
            checkOutput("req_ready", io_req_ready, mGrant);
        end
        if (reset === 1'b0) begin
            mRr        = 0;
            mErr       = 1'b0;
            mCnt       = '0;
            eV0        = 1'b0;
            eV1        = 1'b0;
            eA0        = '0;
            eA1        = '0;
            eD0        = '0;
            eD1        = '0;
            modelKnown = 1'b1;
        end else if (modelKnown) begin
            eV0 = mS0V;
            eA0 = mS0A;
            eD0 = mS0D;
            eV1 = mS1V;
            eA1 = mS1A;
            eD1 = mS1D;
            if (mAny) mRr = (mLast + 1) % NUM_REQ;
            if (mIllegal) mErr = 1'b1;
            if (mConflict && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        end
    end

    task automatic applyStimulus(input logic rstN, input logic stall,
                                 input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_REQ*ADDR_W-1:0] addrs);
        reset        = rstN;
        io_stall     = stall;
        io_req_valid = valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqAddr[i] = addrs[i*ADDR_W +: ADDR_W];
            reqData[i] = dataFor(i);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #2;
    endtask

    task automatic sampleNow();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, '0, '0);
        nextCycle();
        nextCycle();

        // Four distinct addresses from pointer 0: two grants per cycle.
        applyStimulus(1'b1, 1'b0, 4'b1111, {7'd8, 7'd7, 7'd6, 7'd5});
        sampleNow();
        checkOutput("pin_ready_c1", io_req_ready, 4'b0011);
        nextCycle();
        sampleNow();
        checkOutput("pin_ready_c2", io_req_ready, 4'b1100);
        checkOutput("pin_p0_valid", io_write_ports_0_valid, 1'b1);
        checkOutput("pin_p0_addr", io_write_ports_0_bits_addr, 7'd5);
        checkOutput("pin_p0_data", io_write_ports_0_bits_data, dataFor(0));
        checkOutput("pin_p1_valid", io_write_ports_1_valid, 1'b1);
        checkOutput("pin_p1_addr", io_write_ports_1_bits_addr, 7'd6);
        checkOutput("pin_p1_data", io_write_ports_1_bits_data, dataFor(1));

        // Same-address pair: second requester waits a cycle and is counted as a conflict.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b0011, {7'd0, 7'd0, 7'd9, 7'd9});
        sampleNow();
        checkOutput("pin_conf_ready", io_req_ready, 4'b0001);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b0010, {7'd0, 7'd0, 7'd9, 7'd9});
        sampleNow();
        checkOutput("pin_conf_ready2", io_req_ready, 4'b0010);
        checkOutput("pin_conf_p1_valid", io_write_ports_1_valid, 1'b0);
        checkOutput("pin_conf_count", io_conflict_count, 16'd1);

        // Zero and out-of-range addresses are accepted but never written.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b1100, {7'd100, 7'd0, 7'd0, 7'd0});
        sampleNow();
        checkOutput("pin_supp_ready", io_req_ready, 4'b1100);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b0010, {7'd0, 7'd0, 7'd10, 7'd0});
        sampleNow();
        checkOutput("pin_supp_p0_valid", io_write_ports_0_valid, 1'b0);
        checkOutput("pin_supp_p1_valid", io_write_ports_1_valid, 1'b0);
        checkOutput("pin_supp_err", io_err_addr, 1'b1);

        // Stall freezes grants; the pointer (now 2) is kept for the release cycle.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 4'b1111, {7'd14, 7'd13, 7'd12, 7'd11});
        sampleNow();
        checkOutput("pin_stall_ready", io_req_ready, 4'b0000);
        nextCycle();
        sampleNow();
        checkOutput("pin_stall_p0_valid", io_write_ports_0_valid, 1'b0);
        checkOutput("pin_stall_p1_valid", io_write_ports_1_valid, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b1111, {7'd14, 7'd13, 7'd12, 7'd11});
        sampleNow();
        checkOutput("pin_release_ready", io_req_ready, 4'b1100);

        // Reset mid-stream while port 0 carries a write.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd3});
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'b1111, {7'd23, 7'd22, 7'd21, 7'd20});
        sampleNow();
        checkOutput("pin_rst_p0_before", io_write_ports_0_valid, 1'b1);
        checkOutput("pin_rst_ready", io_req_ready, 4'b0000);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b1111, {7'd23, 7'd22, 7'd21, 7'd20});
        sampleNow();
        checkOutput("pin_rst_p0_valid", io_write_ports_0_valid, 1'b0);
        checkOutput("pin_rst_p0_addr", io_write_ports_0_bits_addr, 7'd0);
        checkOutput("pin_rst_p0_data", io_write_ports_0_bits_data, 65'd0);
        checkOutput("pin_rst_p1_valid", io_write_ports_1_valid, 1'b0);
        checkOutput("pin_rst_err", io_err_addr, 1'b0);
        checkOutput("pin_rst_count", io_conflict_count, 16'd0);
        checkOutput("pin_rst_first_ready", io_req_ready, 4'b0011);

        // Randomized traffic with occasional stalls and resets.
        for (int c = 0; c < 3000; c++) begin
            nextCycle();
            reset    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            io_stall = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                io_req_valid[i] = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
                reqAddr[i]      = randAddr();
                reqData[i]      = DATA_W'({$urandom(), $urandom(), $urandom()});
            end
        end

        // Drive the conflict counter into saturation.
        nextCycle();
        applyStimulus(1'b0, 1'b0, '0, '0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b0011, {7'd0, 7'd0, 7'd9, 7'd9});
        repeat (65534) nextCycle();
        nextCycle();
        sampleNow();
        checkOutput("pin_sat_reach", io_conflict_count, 16'hFFFF);
        nextCycle();
        sampleNow();
        checkOutput("pin_sat_hold", io_conflict_count, 16'hFFFF);

        nextCycle();
        applyStimulus(1'b1, 1'b0, '0, '0);
        nextCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of writeback requesters.
REQ-002 Parameter ADDR_W, default 7: register address width.
REQ-003 Parameter DATA_W, default 65: register data width.
REQ-004 Parameter NUM_ENTRIES, default 96: number of physical registers. Addresses >= NUM_ENTRIES are illegal.
REQ-005 Port clock, input, 1: the single clock. All logic is on the rising edge.
REQ-006 Port reset, input, 1: reset, synchronous and active-low.
REQ-007 Port io_stall, input, 1: when high, grants are frozen.
REQ-008 Port io_req_valid, input, NUM_REQ: per-requester write request.
REQ-009 Port io_req_addr, input, NUM_REQ*ADDR_W: requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-010 Port io_req_data, input, NUM_REQ*DATA_W: requester i uses bits [i*DATA_W +: DATA_W].
REQ-011 Port io_req_ready, output, NUM_REQ: combinational grant. A request is transferred when valid and ready are both high.
REQ-012 Ports io_write_ports_0_valid/_bits_addr/_bits_data, output, 1/ADDR_W/DATA_W: register-file write port 0, registered.
REQ-013 Ports io_write_ports_1_valid/_bits_addr/_bits_data, output, 1/ADDR_W/DATA_W: register-file write port 1, registered.
REQ-014 Port io_err_addr, output, 1: sticky flag; an illegal address was accepted.
REQ-015 Port io_conflict_count, output, 16: saturating count of same-address conflict cycles.

Function
REQ-016 Each cycle, scan requesters in round-robin order starting at pointer rr. Grant at most 2 valid requests: the first found to slot 0, the second to slot 1.
REQ-017 The slot-1 candidate shall have an address different from the slot-0 address. A same-address candidate is skipped, keeps ready low, and the scan continues.
REQ-018 io_req_ready[i] is high only for granted requesters. It is 0 when io_stall is high or reset is asserted.
REQ-019 Latency is 1 cycle: an accepted slot-k request drives io_write_ports_k_* on the next cycle.
REQ-020 io_write_ports_k_valid is 0 in every cycle following a cycle with no slot-k grant.
REQ-021 Address 0 requests are accepted; the write is suppressed (valid 0 next cycle) and the request does not occupy a write port.
REQ-022 Requests with address >= NUM_ENTRIES are accepted and suppressed. Acceptance sets io_err_addr, which stays set until reset.
REQ-023 A suppressed request does not occupy a slot; scanning continues for a real write.
REQ-024 The two write ports never carry the same valid address in the same cycle.
REQ-025 rr advances to (index of the last granted requester + 1) mod NUM_REQ. rr is unchanged when nothing is granted.
REQ-026 io_conflict_count increments by 1 in each cycle in which at least one valid request is denied only because of REQ-017. It saturates at 16'hFFFF.
REQ-027 No backpressure from the register file: write ports always accept.
REQ-028 io_stall high: no grants; write-port valids are 0 on the next cycle; rr holds; the counter does not increment.

Reset
REQ-029 While reset is low at a clock edge, the following are cleared: both write-port valids, addrs and data; rr; io_err_addr; io_conflict_count.
REQ-030 A request presented during a reset cycle is not accepted and produces no write.
REQ-031 The first grant occurs in the first cycle with reset high.

Structure
REQ-032 A shared package holds the defaults for NUM_REQ, ADDR_W, DATA_W, NUM_ENTRIES and the counter width 16.
REQ-033 The round-robin first/second-pick logic is one sub-module, rr_pick2. rf_write_arbiter instantiates it once and holds the output registers, rr, the error flag and the counter.

Verification
REQ-034 Requesters 0..3 valid with addrs 5,6,7,8, rr=0:
- Cycle 1: ready=4'b0011; next cycle port0=(5,d0), port1=(6,d1); rr=2.
- Cycle 2: ready=4'b1100.
REQ-035 Requesters 0 and 1 both at addr 9, rr=0 → ready=4'b0001, port1 valid 0, count becomes 1. On the next cycle requester 1 is granted.
REQ-036 Requester 2 addr 0 and requester 3 addr 100, rr=2 → ready=4'b1100, both port valids 0 next cycle, io_err_addr=1.
REQ-037 io_stall=1 with all requests valid → ready=0 and valids 0 next cycle. After releasing stall, the grant order resumes from the held rr.
REQ-038 Reset low mid-stream while port0 is valid → next cycle all outputs and the counter are 0 and rr=0. Counter at 16'hFFFF plus a conflict cycle → stays 16'hFFFF.
